dmem_ctrl: RTL and testbench

- Data-memory block directly downstream of the CPU core's MEM-stage memory port.
- Consumes the core's address, read/write strobes, store data, byte lanes and clear request; returns load data.
- Holds a single-port, word-organised, byte-writable RAM with synchronous read.
- Adds a clear sequencer (zero-fill FSM) plus illegal-lane-mask and out-of-range detection.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_ram.sv | 44 ++++
 rtl/dmem_ctrl.sv | 146 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory controller.
//   - state_t      : clear-sequencer states (IDLE, CLEAR)
//   - LANES        : byte lanes per data word
//   - BM_*         : the seven byte-mark patterns the core may issue
//   - bm_legal()   : returns 1 when a byte mark is one of those patterns
package dmem_pkg;

  localparam int DMEM_DATA_WIDTH = 32;
  localparam int LANES           = DMEM_DATA_WIDTH / 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Single bytes, aligned halves, full word.
  localparam logic [LANES-1:0] BM_B0 = 4'b0001;
  localparam logic [LANES-1:0] BM_B1 = 4'b0010;
  localparam logic [LANES-1:0] BM_B2 = 4'b0100;
  localparam logic [LANES-1:0] BM_B3 = 4'b1000;
  localparam logic [LANES-1:0] BM_H0 = 4'b0011;
  localparam logic [LANES-1:0] BM_H1 = 4'b1100;
  localparam logic [LANES-1:0] BM_W  = 4'b1111;

  function automatic logic bm_legal(input logic [LANES-1:0] bm);
    logic ok;
    case (bm)
      BM_B0, BM_B1, BM_B2, BM_B3, BM_H0, BM_H1, BM_W: ok = 1'b1;
      default:                                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port, word-organised, byte-writable RAM.
//   clk   : clock, rising edge
//   re    : read enable; rdata updates only when re=1, otherwise holds
//   we    : per-lane write enables (bit n = byte n)
//   addr  : word index
//   wdata : write data, lane-aligned
//   rdata : registered read data (latency 1), write-first on the same port
// Contents are never reset. Each lane is its own array so every storage
// element has exactly one writer.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 re,
  input  logic [LANES-1:0]     we,
  input  logic [AW-1:0]        addr,
  input  logic [8*LANES-1:0]   wdata,
  output logic [8*LANES-1:0]   rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
        if (we[gi]) begin
          mem[addr] <= wdata[gi*8 +: 8];
        end
        // Write-first: a lane written this cycle returns the new byte.
        if (re) begin
          rd_q <= we[gi] ? wdata[gi*8 +: 8] : mem[addr];
        end
      end

      assign rdata[gi*8 +: 8] = rd_q;
    end
  endgenerate

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory block behind the core's MEM-stage port.
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset (RAM contents kept)
//   rd_i, wr_i  : load / store request
//   add_i       : byte address; word index = add_i[AW+1:2], bits [1:0] ignored
//   data_i      : lane-aligned store data
//   byte_mark_i : lane enables
//   clr_i       : zero-fill request pulse
//   data_o      : load data, one cycle after the read edge, held otherwise
//   busy_o      : zero-fill in progress (exactly DEPTH cycles)
//   err_o       : one-cycle pulse after an access that was dropped
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_i,
  input  logic                  wr_i,
  input  logic [31:0]           add_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [3:0]            byte_mark_i,
  input  logic                  clr_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o,
  output logic                  err_o
);

  state_t        state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          err_reg, err_next;
  logic          out_sel_reg, out_sel_next;

  logic [AW-1:0]         word_idx;
  logic                  in_range;
  logic                  access;
  logic                  clr_take;
  logic                  valid_acc;
  logic                  unused_addr_bits;

  logic                  ram_re;
  logic [LANES-1:0]      ram_we;
  logic [AW-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign word_idx         = add_i[AW+1:2];
  assign in_range         = (add_i[31:AW+2] == '0);
  assign unused_addr_bits = ^add_i[1:0];
  assign access           = rd_i | wr_i;

  // A clear request taken in IDLE wins over any access in the same cycle;
  // that access is silently dropped (no error pulse).
  assign clr_take  = (state_reg == IDLE) && clr_i;
  assign valid_acc = access && (state_reg == IDLE) && !clr_i && in_range
                     && bm_legal(byte_mark_i);

  // ---------------- clear sequencer ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
      out_sel_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      err_reg     <= err_next;
      out_sel_reg <= out_sel_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (clr_i) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        if (cnt_reg == AW'(DEPTH - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + AW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------- access qualification ----------------
  always_comb begin
    err_next     = access && !clr_take && !valid_acc;
    out_sel_next = out_sel_reg;
    // data_o shows the RAM read register after a legal read and zero after a
    // dropped one; with no read it keeps whatever it showed before.
    if (rd_i && !clr_take) begin
      out_sel_next = valid_acc;
    end
  end

  // ---------------- single RAM port mux ----------------
  always_comb begin
    ram_re    = 1'b0;
    ram_we    = '0;
    ram_addr  = word_idx;
    ram_wdata = data_i;
    if (state_reg == CLEAR) begin
      ram_we    = '1;
      ram_addr  = cnt_reg;
      ram_wdata = '0;
    end else if (valid_acc) begin
      ram_re = rd_i;
      ram_we = wr_i ? byte_mark_i : '0;
    end
  end

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // The RAM read register only moves on legal reads, so gating it with
  // out_sel_reg yields the required hold / zero behaviour without a copy.
  assign data_o = out_sel_reg ? ram_rdata : '0;
  assign busy_o = (state_reg == CLEAR);
  assign err_o  = err_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_i = 1'b0;
  logic        wr_i = 1'b0;
  logic [31:0] add_i = '0;
  logic [31:0] data_i = '0;
  logic [3:0]  byte_mark_i = '0;
  logic        clr_i = 1'b0;
  logic [31:0] data_o;
  logic        busy_o;
  logic        err_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.DATA_WIDTH(32), .DEPTH(256)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_i        (rd_i),
    .wr_i        (wr_i),
    .add_i       (add_i),
    .data_i      (data_i),
    .byte_mark_i (byte_mark_i),
    .clr_i       (clr_i),
    .data_o      (data_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  // One clock transaction: drive at negedge, sample 1 ns after the posedge.
  task automatic cyc(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] mark,
                     input logic clr);
    @(negedge clk);
    rd_i = rd; wr_i = wr; add_i = addr; data_i = data;
    byte_mark_i = mark; clr_i = clr;
    @(posedge clk);
    #1;
    $display("txn t=%0t rd=%0b wr=%0b add=%h din=%h mark=%b clr=%0b -> dout=%h busy=%0b err=%0b",
             $time, rd, wr, addr, data, mark, clr, data_o, busy_o, err_o);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL reset_data_o: got %h expected %h", data_o, 32'h0); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_word();
    cyc(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0);
    cyc(1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0);
    checks++; if (data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL full_word_rd: got %h expected %h", data_o, 32'hDEADBEEF); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL full_word_err: got %b expected 0", err_o); end
    idle();
    checks++; if (data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL full_word_hold: got %h expected %h", data_o, 32'hDEADBEEF); end
  endtask

  task automatic test_merge();
    cyc(1'b0, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, 1'b0);
    cyc(1'b0, 1'b1, 32'h10, 32'h12340000, 4'b1100, 1'b0);
    cyc(1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0);
    checks++; if (data_o !== 32'h1234AAEF) begin failures++; $display("FAIL merge_rd: got %h expected %h", data_o, 32'h1234AAEF); end
    // Low address bits do not affect word selection.
    cyc(1'b1, 1'b0, 32'h13, 32'h0, 4'b0001, 1'b0);
    checks++; if (data_o !== 32'h1234AAEF) begin failures++; $display("FAIL merge_rd_unaligned: got %h expected %h", data_o, 32'h1234AAEF); end
  endtask

  task automatic test_rdwr_same();
    cyc(1'b0, 1'b1, 32'h20, 32'h11111111, 4'b1111, 1'b0);
    cyc(1'b1, 1'b1, 32'h20, 32'h000000FF, 4'b0001, 1'b0);
    checks++; if (data_o !== 32'h111111FF) begin failures++; $display("FAIL rdwr_write_first: got %h expected %h", data_o, 32'h111111FF); end
    cyc(1'b1, 1'b0, 32'h20, 32'h0, 4'b1111, 1'b0);
    checks++; if (data_o !== 32'h111111FF) begin failures++; $display("FAIL rdwr_stored: got %h expected %h", data_o, 32'h111111FF); end
  endtask

  task automatic test_illegal();
    cyc(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0101, 1'b0);
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL illegal_mark_err: got %b expected 1", err_o); end
    idle();
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL illegal_mark_err_width: got %b expected 0", err_o); end
    cyc(1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0);
    checks++; if (data_o !== 32'h1234AAEF) begin failures++; $display("FAIL illegal_mark_nowrite: got %h expected %h", data_o, 32'h1234AAEF); end
    // Out-of-range store must not alias onto word 0.
    cyc(1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 4'b1111, 1'b0);
    cyc(1'b0, 1'b1, 32'h400, 32'h55555555, 4'b1111, 1'b0);
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL oor_wr_err: got %b expected 1", err_o); end
    cyc(1'b1, 1'b0, 32'h400, 32'h0, 4'b1111, 1'b0);
    checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL oor_rd_data: got %h expected %h", data_o, 32'h0); end
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL oor_rd_err: got %b expected 1", err_o); end
    idle();
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL oor_err_width: got %b expected 0", err_o); end
    checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL oor_data_hold: got %h expected %h", data_o, 32'h0); end
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'b1111, 1'b0);
    checks++; if (data_o !== 32'hA5A5A5A5) begin failures++; $display("FAIL oor_nowrite: got %h expected %h", data_o, 32'hA5A5A5A5); end
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 256; i++) begin
      cyc(1'b0, 1'b1, 32'(i * 4), base | 32'(i), 4'b1111, 1'b0);
    end
  endtask

  task automatic test_clear();
    int busy_cnt;
    bit done;
    fill(32'h1000_0000);
    cyc(1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0);
    checks++; if (data_o !== 32'h1000_0004) begin failures++; $display("FAIL clear_prefill: got %h expected %h", data_o, 32'h1000_0004); end
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL clear_busy_start: got %b expected 1", busy_o); end
    busy_cnt = 1;
    done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      if (k == 50) begin
        cyc(1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, 1'b0);
        checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL clear_busy_rd_data: got %h expected %h", data_o, 32'h0); end
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL clear_busy_rd_err: got %b expected 1", err_o); end
      end else if (k == 60) begin
        // clr_i while clearing must not restart the sequence.
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
      end else begin
        idle();
      end
      if (busy_o) busy_cnt++;
      else done = 1;
    end
    checks++; if (!done || busy_cnt != 256) begin failures++; $display("FAIL clear_busy_len: got %0d expected %0d", busy_cnt, 256); end
    for (int i = 0; i < 256; i++) begin
      cyc(1'b1, 1'b0, 32'(i * 4), 32'h0, 4'b1111, 1'b0);
      checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL clear_word[%0d]: got %h expected %h", i, data_o, 32'h0); end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [31:0] exp;
    fill(32'h2000_0000);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    repeat (100) idle();
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL midclr_busy_before: got %b expected 1", busy_o); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL midclr_busy_async: got %b expected 0", busy_o); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      exp = (i < 100) ? 32'h0 : (32'h2000_0000 | 32'(i));
      cyc(1'b1, 1'b0, 32'(i * 4), 32'h0, 4'b1111, 1'b0);
      checks++; if (data_o !== exp) begin failures++; $display("FAIL midclr_word[%0d]: got %h expected %h", i, data_o, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_merge();
    test_rdwr_same();
    test_illegal();
    test_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
